// File: rtl/election_house_arbiter.sv
// Election-house capture arbiter for two tanks.
// Samples per-frame presence of each tank and walks the shared house through
// capture, contest, award (one-cycle bonus pulse) and a fixed cooldown.
// Optional build macro: ELECTION_DECAY_EN makes an owner's progress decay by
// one per empty frame instead of being discarded immediately.
module election_house_arbiter #(
  parameter int CAPTURE_SEC  = 5,
  parameter int COOLDOWN_SEC = 20,
  parameter int SOF_PER_SEC  = 30
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       start_of_frame,
  input  logic       enable,
  input  logic       collisionTank1Election,
  input  logic       collisionTank2Election,
  output logic       tank1Bonus,
  output logic       tank2Bonus,
  output logic [1:0] owner,
  output logic [9:0] progress,
  output logic       contested,
  output logic       coolingDown
);

  localparam logic [9:0]  CAPTURE_FRAMES  = 10'(CAPTURE_SEC * SOF_PER_SEC);
  localparam logic [15:0] COOLDOWN_FRAMES = 16'(COOLDOWN_SEC * SOF_PER_SEC);

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    CONTEST,
    AWARD,
    COOLDOWN
  } state_t;

  state_t      state, state_next;
  logic [1:0]  owner_next;
  logic [9:0]  progress_next;
  logic [15:0] cd_cnt, cd_next;
  logic        f1, f2, f1_next, f2_next;
  logic        take;
  logic [1:0]  take_owner;
  logic [9:0]  take_progress;
  logic [1:0]  sole;
  logic [1:0]  other;

  // Tank seen alone this frame (only meaningful when exactly one flag is set),
  // and the tank that is not the current owner.
  assign sole  = f1 ? 2'd1 : 2'd2;
  assign other = (owner == 2'd1) ? 2'd2 : 2'd1;

  // Status outputs; a bonus is only granted while the game is still running.
  assign contested   = (state == CONTEST);
  assign coolingDown = (state == COOLDOWN);
  assign tank1Bonus  = (state == AWARD) && enable && (owner == 2'd1);
  assign tank2Bonus  = (state == AWARD) && enable && (owner == 2'd2);

  // Next-state, presence-flag and counter logic; evaluation happens on frame strobes.
  always_comb begin
    state_next    = state;
    owner_next    = owner;
    progress_next = progress;
    cd_next       = cd_cnt;
    f1_next       = start_of_frame ? collisionTank1Election : (f1 | collisionTank1Election);
    f2_next       = start_of_frame ? collisionTank2Election : (f2 | collisionTank2Election);
    take          = 1'b0;
    take_owner    = owner;
    take_progress = progress;

    if (!enable) begin
      state_next    = IDLE;
      owner_next    = 2'd0;
      progress_next = 10'd0;
      cd_next       = 16'd0;
      f1_next       = 1'b0;
      f2_next       = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_of_frame) begin
            case ({f1, f2})
              2'b10:   begin take = 1'b1; take_owner = 2'd1; take_progress = 10'd1; end
              2'b01:   begin take = 1'b1; take_owner = 2'd2; take_progress = 10'd1; end
              2'b11:   state_next = CONTEST;
              default: state_next = IDLE;
            endcase
          end
        end
        CAPTURE: begin
          if (start_of_frame) begin
            case ({f1, f2})
              2'b11: state_next = CONTEST;
              2'b00: begin
`ifdef ELECTION_DECAY_EN
                if (progress > 10'd1) begin
                  progress_next = progress - 10'd1;
                end else begin
                  state_next    = IDLE;
                  owner_next    = 2'd0;
                  progress_next = 10'd0;
                end
`else
                state_next    = IDLE;
                owner_next    = 2'd0;
                progress_next = 10'd0;
`endif
              end
              default: begin
                take = 1'b1;
                if (sole == owner) begin
                  take_owner    = owner;
                  take_progress = progress + 10'd1;
                end else begin
                  take_owner    = other;
                  take_progress = 10'd1;
                end
              end
            endcase
          end
        end
        CONTEST: begin
          if (start_of_frame) begin
            case ({f1, f2})
              2'b11: state_next = CONTEST;
              2'b00: begin
                state_next    = IDLE;
                owner_next    = 2'd0;
                progress_next = 10'd0;
              end
              default: begin
                take       = 1'b1;
                take_owner = sole;
                if (sole == owner) take_progress = progress + 10'd1;
                else               take_progress = 10'd1;
              end
            endcase
          end
        end
        AWARD: begin
          state_next    = COOLDOWN;
          owner_next    = 2'd0;
          progress_next = 10'd0;
          cd_next       = 16'd0;
          f1_next       = 1'b0;
          f2_next       = 1'b0;
        end
        COOLDOWN: begin
          f1_next = 1'b0;
          f2_next = 1'b0;
          if (start_of_frame) begin
            if (cd_cnt + 16'd1 == COOLDOWN_FRAMES) begin
              state_next = IDLE;
              cd_next    = 16'd0;
            end else begin
              cd_next = cd_cnt + 16'd1;
            end
          end
        end
        default: state_next = IDLE;
      endcase

      if (take) begin
        owner_next    = take_owner;
        progress_next = take_progress;
        state_next    = (take_progress == CAPTURE_FRAMES) ? AWARD : CAPTURE;
      end
    end
  end

  // State, ownership, counters and sticky presence flags.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE;
      owner    <= 2'd0;
      progress <= 10'd0;
      cd_cnt   <= 16'd0;
      f1       <= 1'b0;
      f2       <= 1'b0;
    end else begin
      state    <= state_next;
      owner    <= owner_next;
      progress <= progress_next;
      cd_cnt   <= cd_next;
      f1       <= f1_next;
      f2       <= f2_next;
    end
  end

endmodule
